// File: rtl/pattern_generator_gen2.sv
// pattern_generator_gen2
//   Parametrised test-pattern source. After each line sync it emits LINE_LEN
//   pixels, one per clk, tracking row/column, with a valid strobe, an
//   end-of-line pulse and an abort pulse when a sync cuts a line short.
//   Mode/constVal/X/Y are shadowed and only take effect at a frame start
//   (sync & f_sync).
// Ports
//   clk        master clock
//   rst_n      asynchronous active-low reset
//   f_sync     first-line marker, only meaningful together with sync
//   sync       line start pulse
//   constVal   constant-mode pixel value
//   X, Y       ramp delta per pixel / per line
//   Mode       pattern select
//   cnt        registered pixel value
//   cnt_valid  cnt holds an active pixel
//   line_end   pulses with the last pixel of a line
//   line_abort pulses with col 0 of a line restarted by a mid-line sync
module pattern_generator_gen2 #(
  parameter int unsigned DATA_W   = 12,
  parameter int unsigned LINE_LEN = 1350,
  parameter int unsigned ROW_W    = 12,
  parameter int unsigned CHK_LOG2 = 1,
  parameter int unsigned D_W      = 2,
  parameter bit          SAT_RAMP = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_sync,
  input  logic              sync,
  input  logic [DATA_W-1:0] constVal,
  input  logic [D_W-1:0]    X,
  input  logic [D_W-1:0]    Y,
  input  logic [2:0]        Mode,
  output logic [DATA_W-1:0] cnt,
  output logic              cnt_valid,
  output logic              line_end,
  output logic              line_abort
);

  localparam int unsigned CW = $clog2(LINE_LEN + 1);
  localparam logic [CW-1:0] LAST_COL = CW'(LINE_LEN - 1);

  typedef enum logic [2:0] {
    MODE_IDLE   = 3'b000,
    MODE_COUNT  = 3'b001,
    MODE_CONST  = 3'b010,
    MODE_WHITE1 = 3'b011,
    MODE_BLACK1 = 3'b100,
    MODE_WHITEN = 3'b101,
    MODE_BLACKN = 3'b110,
    MODE_RAMP   = 3'b111
  } mode_e;

  // Shadowed configuration
  mode_e             mode_q;
  logic [DATA_W-1:0] const_q;
  logic [D_W-1:0]    x_q;
  logic [D_W-1:0]    y_q;

  // Line / pixel tracking. pix_col is the column that the next edge puts on
  // cnt, so the output stage runs one cycle behind the sync.
  logic [ROW_W-1:0]  row_q;
  logic              pix_active;
  logic [CW-1:0]     pix_col;
  logic              abort_pend;

  // Ramp state
  logic [DATA_W-1:0] base_q;
  logic [DATA_W-1:0] acc_q;

  logic              frame_start;
  logic [DATA_W-1:0] base_d;
  logic [DATA_W-1:0] pix_value;
  logic              chk1;
  logic              chkn;

  // Adds a delta with one guard bit; saturation is sticky because deltas are
  // non-negative and an all-ones operand can only overflow again.
  function automatic logic [DATA_W-1:0] ramp_add(input logic [DATA_W-1:0] a,
                                                 input logic [D_W-1:0]    d);
    logic [DATA_W:0] s;
    s = {1'b0, a} + (DATA_W + 1)'(d);
    if (SAT_RAMP && s[DATA_W]) return '1;
    return s[DATA_W-1:0];
  endfunction

  always_comb begin
    frame_start = sync & f_sync;
    base_d      = frame_start ? '0 : ramp_add(base_q, y_q);
    chk1        = pix_col[0] ^ row_q[0];
    chkn        = pix_col[CHK_LOG2] ^ row_q[CHK_LOG2];
    pix_value   = '0;
    case (mode_q)
      MODE_COUNT:  pix_value = DATA_W'(pix_col);
      MODE_CONST:  pix_value = const_q;
      MODE_WHITE1: pix_value = chk1 ? '0 : '1;
      MODE_BLACK1: pix_value = chk1 ? '1 : '0;
      MODE_WHITEN: pix_value = chkn ? '0 : '1;
      MODE_BLACKN: pix_value = chkn ? '1 : '0;
      MODE_RAMP:   pix_value = acc_q;
      default:     pix_value = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= MODE_IDLE;
      const_q    <= '0;
      x_q        <= '0;
      y_q        <= '0;
      row_q      <= '0;
      pix_active <= 1'b0;
      pix_col    <= '0;
      abort_pend <= 1'b0;
      base_q     <= '0;
      acc_q      <= '0;
      cnt        <= '0;
      cnt_valid  <= 1'b0;
      line_end   <= 1'b0;
      line_abort <= 1'b0;
    end else begin
      // Output stage: the pixel for pix_col, using the config of its line.
      if (pix_active) begin
        cnt       <= pix_value;
        cnt_valid <= (mode_q != MODE_IDLE);
        line_end  <= (pix_col == LAST_COL);
      end else begin
        cnt       <= '0;
        cnt_valid <= 1'b0;
        line_end  <= 1'b0;
      end

      // pix_col != 0 while active means a pixel other than the last one is
      // currently on cnt; the abort pulse is delayed to line up with col 0.
      abort_pend <= sync && pix_active && (pix_col != '0);
      line_abort <= abort_pend;

      if (sync) begin
        pix_active <= 1'b1;
        pix_col    <= '0;
        base_q     <= base_d;
        acc_q      <= base_d;
        if (frame_start) begin
          row_q   <= '0;
          mode_q  <= mode_e'(Mode);
          const_q <= constVal;
          x_q     <= X;
          y_q     <= Y;
        end else begin
          row_q <= row_q + ROW_W'(1);
        end
      end else if (pix_active) begin
        pix_col <= pix_col + CW'(1);
        acc_q   <= ramp_add(acc_q, x_q);
        if (pix_col == LAST_COL) pix_active <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pattern_generator_gen2.sv
// tb_pattern_generator_gen2
//   Drives three generator instances (12-bit saturating, 4-bit saturating,
//   4-bit wrapping; LINE_LEN=8) with the same directed and random stimulus
//   and compares every output each cycle against a reference model that
//   works from "edges since the last sync" and closed-form pixel formulas.
module tb_pattern_generator_gen2;
  localparam int L = 8;

  logic        clk = 1'b0;
  logic        rst_n, f_sync, sync;
  logic [11:0] cv;
  logic [1:0]  x, y;
  logic [2:0]  mode;

  logic [11:0] cnt_a;
  logic [3:0]  cnt_s, cnt_w;
  logic        v_a, le_a, ab_a, v_s, le_s, ab_s, v_w, le_w, ab_w;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #8 clk = ~clk;

  pattern_generator_gen2 #(.DATA_W(12), .LINE_LEN(L), .ROW_W(12), .CHK_LOG2(1),
                           .D_W(2), .SAT_RAMP(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .f_sync(f_sync), .sync(sync), .constVal(cv),
    .X(x), .Y(y), .Mode(mode), .cnt(cnt_a), .cnt_valid(v_a),
    .line_end(le_a), .line_abort(ab_a));

  pattern_generator_gen2 #(.DATA_W(4), .LINE_LEN(L), .ROW_W(12), .CHK_LOG2(1),
                           .D_W(2), .SAT_RAMP(1'b1)) u_s (
    .clk(clk), .rst_n(rst_n), .f_sync(f_sync), .sync(sync), .constVal(cv[3:0]),
    .X(x), .Y(y), .Mode(mode), .cnt(cnt_s), .cnt_valid(v_s),
    .line_end(le_s), .line_abort(ab_s));

  pattern_generator_gen2 #(.DATA_W(4), .LINE_LEN(L), .ROW_W(12), .CHK_LOG2(1),
                           .D_W(2), .SAT_RAMP(1'b0)) u_w (
    .clk(clk), .rst_n(rst_n), .f_sync(f_sync), .sync(sync), .constVal(cv[3:0]),
    .X(x), .Y(y), .Mode(mode), .cnt(cnt_w), .cnt_valid(v_w),
    .line_end(le_w), .line_abort(ab_w));

  // Reference model state
  longint e_cnt, last_sync, m_n, l_n;
  bit     have_sync, abort_flag;
  int     m_mode, m_cv, m_x, m_y, l_mode, l_cv, l_x, l_y;

  logic [31:0] x_cnt_a, x_cnt_s, x_cnt_w;
  logic        x_valid, x_end, x_abort;

  // Pixel value for column c of the n-th line since frame start.
  function automatic longint pix(int dw, bit sat, int md, longint c, longint n,
                                 longint cvv, longint xx, longint yy);
    longint m, ones, r, b, v;
    m    = longint'(1) << dw;
    ones = m - 1;
    r    = n % 4096;
    case (md)
      1: v = c % m;
      2: v = cvv % m;
      3: v = (((c ^ r) & 1) == 0) ? ones : 0;
      4: v = (((c ^ r) & 1) == 0) ? 0 : ones;
      5: v = ((((c >> 1) ^ (r >> 1)) & 1) == 0) ? ones : 0;
      6: v = ((((c >> 1) ^ (r >> 1)) & 1) == 0) ? 0 : ones;
      7: begin
        if (sat) begin
          b = n * yy;
          if (b > ones) b = ones;
          v = b + c * xx;
          if (v > ones) v = ones;
        end else begin
          v = ((n * yy) % m + c * xx) % m;
        end
      end
      default: v = 0;
    endcase
    return v;
  endfunction

  task automatic model_reset();
    have_sync  = 1'b0;
    abort_flag = 1'b0;
    m_n = 0; l_n = 0;
    m_mode = 0; m_cv = 0; m_x = 0; m_y = 0;
    l_mode = 0; l_cv = 0; l_x = 0; l_y = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    assert (act === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("cnt12",   32'(cnt_a), x_cnt_a);
    chk("valid12", 32'(v_a),   32'(x_valid));
    chk("end12",   32'(le_a),  32'(x_end));
    chk("abort12", 32'(ab_a),  32'(x_abort));
    chk("cnt4s",   32'(cnt_s), x_cnt_s);
    chk("valid4s", 32'(v_s),   32'(x_valid));
    chk("cnt4w",   32'(cnt_w), x_cnt_w);
    chk("end4w",   32'(le_w),  32'(x_end));
    chk("abort4w", 32'(ab_w),  32'(x_abort));
  endtask

  // One clock: update the model from the inputs sampled at the edge, then
  // compare on the falling edge.
  task automatic tick();
    longint d;
    @(posedge clk);
    x_cnt_a = '0; x_cnt_s = '0; x_cnt_w = '0;
    x_valid = 1'b0; x_end = 1'b0; x_abort = 1'b0;
    if (!rst_n) begin
      model_reset();
    end else begin
      d = e_cnt - last_sync;
      if (have_sync && d >= 1 && d <= L) begin
        x_valid = (l_mode != 0);
        x_end   = (d == L);
        x_cnt_a = 32'(pix(12, 1'b1, l_mode, d - 1, l_n, l_cv, l_x, l_y));
        x_cnt_s = 32'(pix(4,  1'b1, l_mode, d - 1, l_n, l_cv, l_x, l_y));
        x_cnt_w = 32'(pix(4,  1'b0, l_mode, d - 1, l_n, l_cv, l_x, l_y));
      end
      x_abort    = abort_flag;
      abort_flag = sync && have_sync && d >= 2 && d <= L;
      if (sync) begin
        last_sync = e_cnt;
        have_sync = 1'b1;
        if (f_sync) begin
          m_n = 0;
          m_mode = int'(mode); m_cv = int'(cv); m_x = int'(x); m_y = int'(y);
        end else begin
          m_n++;
        end
        l_n = m_n; l_mode = m_mode; l_cv = m_cv; l_x = m_x; l_y = m_y;
      end
    end
    e_cnt++;
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic line_start(input bit f);
    sync = 1'b1; f_sync = f;
    tick();
    sync = 1'b0; f_sync = 1'b0;
  endtask

  task automatic cfg(input logic [2:0] md, input logic [11:0] c,
                     input logic [1:0] xx, input logic [1:0] yy);
    mode = md; cv = c; x = xx; y = yy;
  endtask

  initial begin
    e_cnt = 0; last_sync = 0;
    model_reset();
    rst_n = 1'b1; sync = 1'b0; f_sync = 1'b0;
    cfg(3'b000, 12'd0, 2'd0, 2'd0);
    #3 rst_n = 1'b0;
    #1;
    x_cnt_a = '0; x_cnt_s = '0; x_cnt_w = '0;
    x_valid = 1'b0; x_end = 1'b0; x_abort = 1'b0;
    check_all();
    idle(2);
    rst_n = 1'b1;
    idle(2);

    // Count mode, single frame-start line
    cfg(3'b001, 12'd0, 2'd0, 2'd0);
    line_start(1'b1);
    idle(10);

    // Constant mode: shadowed value until next frame start
    cfg(3'b010, 12'd12, 2'd0, 2'd0);
    line_start(1'b1);
    idle(9);
    cv = 12'd99;
    line_start(1'b0); idle(9);
    line_start(1'b0); idle(9);
    line_start(1'b1); idle(9);

    // Checkers, 2x2 then 1x1, both polarities
    for (int m = 5; m <= 6; m++) begin
      cfg(3'(m), 12'd0, 2'd0, 2'd0);
      line_start(1'b1); idle(9);
      for (int i = 0; i < 3; i++) begin line_start(1'b0); idle(9); end
    end
    for (int m = 3; m <= 4; m++) begin
      cfg(3'(m), 12'd0, 2'd0, 2'd0);
      line_start(1'b1); idle(9);
      line_start(1'b0); idle(9);
    end

    // Ramps: X=2,Y=2 through row 3; X=3 hits 4-bit saturation/wrap on row 0
    cfg(3'b111, 12'd0, 2'd2, 2'd2);
    line_start(1'b1); idle(9);
    for (int i = 0; i < 3; i++) begin line_start(1'b0); idle(9); end
    cfg(3'b111, 12'd0, 2'd3, 2'd2);
    line_start(1'b1); idle(9);
    for (int i = 0; i < 8; i++) begin line_start(1'b0); idle(8); end

    // Abort: sync while col 4 is on cnt; then back-to-back with no abort
    cfg(3'b001, 12'd0, 2'd0, 2'd0);
    line_start(1'b1);
    idle(5);
    line_start(1'b0);
    idle(L);
    line_start(1'b0);
    idle(10);

    // Async reset mid-line; shadow mode returns to idle until a frame start
    line_start(1'b1);
    idle(3);
    #2 rst_n = 1'b0;
    #1;
    x_cnt_a = '0; x_cnt_s = '0; x_cnt_w = '0;
    x_valid = 1'b0; x_end = 1'b0; x_abort = 1'b0;
    check_all();
    idle(2);
    rst_n = 1'b1;
    line_start(1'b0); idle(9);
    f_sync = 1'b1; idle(2); f_sync = 1'b0;
    line_start(1'b0); idle(9);
    line_start(1'b1); idle(9);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cfg(3'($urandom_range(0, 7)), 12'($urandom), 2'($urandom), 2'($urandom));
      sync   = ($urandom_range(0, 9) == 0);
      f_sync = ($urandom_range(0, 3) == 0);
      tick();
    end
    sync = 1'b0; f_sync = 1'b0;
    idle(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
